// File: rtl/ddr_chk_pkg.sv
// Shared definitions for the DDR PRBS5 checker: FSM state encoding,
// PRBS5 tap positions and the XNOR lockup history value.
package ddr_chk_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int TAP_A = 4;
  localparam int TAP_B = 2;

  localparam logic [4:0] LOCKUP_H = 5'b11111;

  // Next PRBS5 bit predicted from a history whose bit 0 is the newest bit.
  function automatic logic prbs5_pred(input logic [4:0] h);
    return ~(h[TAP_A] ^ h[TAP_B]);
  endfunction

endpackage

// File: rtl/ddr_prbs_checker_step2.sv
// Two-bit PRBS5 step: predicts the rise and fall bits of one DDR pair and
// returns the history advanced both by the received bits and by the predictions.
module prbs5_step2
  import ddr_chk_pkg::*;
(
  input  logic       [4:0] h,
  input  logic             rx_rise,
  input  logic             rx_fall,
  output logic             p_rise,
  output logic             p_fall,
  output logic       [4:0] h_rx,
  output logic       [4:0] h_pred
);

  logic [4:0] h_mid;

  // The fall prediction uses the history after the rise bit; the taps never
  // touch the newest bit, so it is the same whichever rise bit is shifted in.
  always_comb begin
    p_rise = prbs5_pred(h);
    h_mid  = {h[3:0], rx_rise};
    p_fall = prbs5_pred(h_mid);
    h_rx   = {h[2:0], rx_rise, rx_fall};
    h_pred = {h[2:0], p_rise, p_fall};
  end

endmodule

// File: rtl/ddr_prbs_checker.sv
// DDR PRBS5 checker: self-synchronises to a 2-bit-per-clock PRBS5 stream,
// counts checked bits and errors, and tracks lock / loss-of-lock.
// Optional build macro DDR_CHK_ERR_INJECT_EN adds the inject_err input,
// which inverts the fall bit of valid pairs before checking.
module ddr_prbs_checker
  import ddr_chk_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter int BIT_CNT_W = 24,
  parameter int LOCK_GOOD = 8,
  parameter int LOSS_ERR  = 4,
  parameter int LOSS_WIN  = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 din_rise,
  input  logic                 din_fall,
  input  logic                 clear,
`ifdef DDR_CHK_ERR_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic                 locked,
  output logic                 lost,
  output logic                 lockup,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic [7:0]           status
);

  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int WERR_W = $clog2(LOSS_ERR + 2);
  localparam int WCNT_W = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(LOCK_GOOD);
  localparam logic [WERR_W-1:0] LOSS_LIM = WERR_W'(LOSS_ERR);
  localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(LOSS_WIN - 1);

  chk_state_e          state;
  logic [4:0]          hist;
  logic [1:0]          seed_cnt;
  logic [GOOD_W-1:0]   good_cnt;
  logic [WERR_W-1:0]   win_err;
  logic [WCNT_W-1:0]   win_cnt;
  logic                err_nz;

  logic                fall_in;
  logic                p_rise;
  logic                p_fall;
  logic [4:0]          h_rx;
  logic [4:0]          h_pred;
  logic [1:0]          pair_err;
  logic                chk_en;
  logic [1:0]          cnt_err;
  logic [1:0]          bit_add;
  logic [ERR_CNT_W-1:0] err_base;
  logic [BIT_CNT_W-1:0] bit_base;
  logic [ERR_CNT_W:0]  err_sum;
  logic [BIT_CNT_W:0]  bit_sum;
  logic [ERR_CNT_W-1:0] err_next;
  logic [BIT_CNT_W-1:0] bit_next;
  logic [WERR_W-1:0]   win_sum;
  logic [GOOD_W-1:0]   good_sum;
  logic                loss_hit;
  logic                lost_next;

`ifdef DDR_CHK_ERR_INJECT_EN
  assign fall_in = din_fall ^ (inject_err & din_valid);
`else
  assign fall_in = din_fall;
`endif

  prbs5_step2 u_step (
    .h       (hist),
    .rx_rise (din_rise),
    .rx_fall (fall_in),
    .p_rise  (p_rise),
    .p_fall  (p_fall),
    .h_rx    (h_rx),
    .h_pred  (h_pred)
  );

  // Per-pair error count, saturating counter updates and loss-window sums.
  always_comb begin
    pair_err  = {1'b0, din_rise ^ p_rise} + {1'b0, fall_in ^ p_fall};
    chk_en    = din_valid && (state == LOCKED);
    cnt_err   = chk_en ? pair_err : 2'd0;
    bit_add   = chk_en ? 2'd2 : 2'd0;
    err_base  = clear ? '0 : err_count;
    bit_base  = clear ? '0 : bit_count;
    err_sum   = {1'b0, err_base} + (ERR_CNT_W + 1)'(cnt_err);
    bit_sum   = {1'b0, bit_base} + (BIT_CNT_W + 1)'(bit_add);
    err_next  = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    bit_next  = bit_sum[BIT_CNT_W] ? '1 : bit_sum[BIT_CNT_W-1:0];
    win_sum   = win_err + WERR_W'(pair_err);
    good_sum  = good_cnt + GOOD_W'(2);
    loss_hit  = chk_en && (win_sum >= LOSS_LIM);
    lost_next = loss_hit | (lost & ~clear);
  end

  // Seed / verify / locked sequencing with counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      good_cnt  <= '0;
      win_err   <= '0;
      win_cnt   <= '0;
      err_nz    <= 1'b0;
      locked    <= 1'b0;
      lost      <= 1'b0;
      lockup    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      err_count <= err_next;
      bit_count <= bit_next;
      err_nz    <= |err_next;
      lost      <= lost_next;
      if (din_valid) begin
        case (state)
          SEED: begin
            hist   <= h_rx;
            lockup <= (h_rx == LOCKUP_H);
            if (seed_cnt == 2'd2) begin
              if (h_rx != LOCKUP_H) begin
                state    <= VERIFY;
                seed_cnt <= '0;
                good_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + 2'd1;
            end
          end
          VERIFY: begin
            hist   <= h_rx;
            lockup <= (h_rx == LOCKUP_H);
            if (pair_err != 2'd0) begin
              state    <= SEED;
              good_cnt <= '0;
            end else if (good_sum >= GOOD_LIM) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              win_err  <= '0;
              win_cnt  <= '0;
            end else begin
              good_cnt <= good_sum;
            end
          end
          LOCKED: begin
            // Free-running on predictions keeps a single flipped bit from
            // corrupting the history and being counted again later.
            hist      <= h_pred;
            lockup    <= (h_pred == LOCKUP_H);
            err_pulse <= (pair_err != 2'd0);
            if (loss_hit) begin
              state    <= SEED;
              locked   <= 1'b0;
              seed_cnt <= '0;
              win_err  <= '0;
              win_cnt  <= '0;
            end else if (win_cnt == WIN_LAST) begin
              win_err <= '0;
              win_cnt <= '0;
            end else begin
              win_err <= win_sum;
              win_cnt <= win_cnt + WCNT_W'(1);
            end
          end
          default: begin
            state    <= SEED;
            locked   <= 1'b0;
            seed_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign status = {locked, lost, lockup, err_nz, state, err_count[1:0]};

endmodule
